// File: rtl/axis_pkt_rr_arbiter_if.sv
// Bundle of the NUM_INPUTS packed slave-side AXI-Stream inputs and the single
// master-side AXI-Stream output shared by the packet round-robin arbiter.
interface axis_pkt_rr_arbiter_if #(
   parameter int NUM_INPUTS      = 4,
   parameter int AXIS_BUS_WIDTH  = 64,
   parameter int AXIS_USER_WIDTH = 4
);
   localparam int NUM_BUS_BYTES = AXIS_BUS_WIDTH / 8;

   logic [NUM_INPUTS*AXIS_BUS_WIDTH-1:0]  s_axis_tdata;
   logic [NUM_INPUTS*AXIS_USER_WIDTH-1:0] s_axis_tuser;
   logic [NUM_INPUTS*NUM_BUS_BYTES-1:0]   s_axis_tkeep;
   logic [NUM_INPUTS-1:0]                 s_axis_tlast;
   logic [NUM_INPUTS-1:0]                 s_axis_tvalid;
   logic [NUM_INPUTS-1:0]                 s_axis_tready;

   logic [AXIS_BUS_WIDTH-1:0]             m_axis_tdata;
   logic [AXIS_USER_WIDTH-1:0]            m_axis_tuser;
   logic [NUM_BUS_BYTES-1:0]              m_axis_tkeep;
   logic                                  m_axis_tlast;
   logic                                  m_axis_tvalid;
   logic                                  m_axis_tready;

   // Arbiter side: consumes the input streams, produces the output stream.
   modport slave (
      input  s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
      input  m_axis_tready
   );

   // Environment side: sources the input streams, sinks the output stream.
   modport master (
      output s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
      output m_axis_tready
   );
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: one grant is held from a packet's first
// beat to its tlast beat, and the shared output beat is registered once.
module axis_pkt_rr_arbiter #(
   parameter int NUM_INPUTS      = 4,
   parameter int AXIS_BUS_WIDTH  = 64,
   parameter int AXIS_USER_WIDTH = 4,
   localparam int NUM_BUS_BYTES  = AXIS_BUS_WIDTH / 8,
   localparam int GRANT_WIDTH    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                    aclk,
   input  logic                    areset,
   axis_pkt_rr_arbiter_if.slave    bus,
   input  logic [NUM_INPUTS-1:0]   input_enable,
   output logic                    grant_valid,
   output logic [GRANT_WIDTH-1:0]  grant_idx
);

   typedef enum logic {IDLE, PASS} state_t;

   state_t                     state, state_nxt;
   logic [GRANT_WIDTH-1:0]     grant_nxt, last_grant, pick_idx;
   logic [NUM_INPUTS-1:0]      req, ready;
   logic                       pick_found, slot_free, accept;

   // _p0: beat currently offered by the granted input; _p1: output register
   logic [AXIS_BUS_WIDTH-1:0]  data_p0, data_p1;
   logic [AXIS_USER_WIDTH-1:0] user_p0, user_p1;
   logic [NUM_BUS_BYTES-1:0]   keep_p0, keep_p1;
   logic                       last_p0, last_p1;
   logic                       vld_p0,  vld_p1;

   // Enables only matter while choosing, so they are folded into the request here
   assign req       = bus.s_axis_tvalid & input_enable;
   assign slot_free = ~vld_p1 | bus.m_axis_tready;

   // Round-robin pick: first requester strictly after the last packet's owner, wrapping
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         if (!pick_found && req[(int'(last_grant) + k) % NUM_INPUTS]) begin
            pick_found = 1'b1;
            pick_idx   = GRANT_WIDTH'((int'(last_grant) + k) % NUM_INPUTS);
         end
      end
   end

   // Select the granted input's beat
   always_comb begin
      data_p0 = bus.s_axis_tdata[int'(grant_idx)*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
      user_p0 = bus.s_axis_tuser[int'(grant_idx)*AXIS_USER_WIDTH +: AXIS_USER_WIDTH];
      keep_p0 = bus.s_axis_tkeep[int'(grant_idx)*NUM_BUS_BYTES +: NUM_BUS_BYTES];
      last_p0 = bus.s_axis_tlast[grant_idx];
      vld_p0  = bus.s_axis_tvalid[grant_idx];
   end

   // FSM next state and outputs: choose in IDLE, forward until tlast in PASS
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_idx;
      ready     = '0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = PASS;
               grant_nxt = pick_idx;
            end
         end
         PASS: begin
            ready[grant_idx] = slot_free;
            accept           = slot_free & vld_p0;
            if (accept && last_p0) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control state: FSM, grant bookkeeping and output valid
   always_ff @(posedge aclk) begin
      if (areset) begin
         state      <= IDLE;
         grant_idx  <= '0;
         last_grant <= GRANT_WIDTH'(NUM_INPUTS - 1);
         vld_p1     <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant_idx <= grant_nxt;
         if (accept && last_p0) begin
            last_grant <= grant_idx;
         end
         if (accept) begin
            vld_p1 <= 1'b1;
         end else if (bus.m_axis_tready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   // Output beat register, loaded only on an accepted input beat
   always_ff @(posedge aclk) begin
      if (accept) begin
         data_p1 <= data_p0;
         user_p1 <= user_p0;
         keep_p1 <= keep_p0;
         last_p1 <= last_p0;
      end
   end

   assign grant_valid       = (state == PASS);
   assign bus.s_axis_tready = ready;
   assign bus.m_axis_tdata  = data_p1;
   assign bus.m_axis_tuser  = user_p1;
   assign bus.m_axis_tkeep  = keep_p1;
   assign bus.m_axis_tlast  = last_p1;
   assign bus.m_axis_tvalid = vld_p1;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Bench for axis_pkt_rr_arbiter: per-input packet sources, a queue-based
// reference of the arbitration rules checked every cycle, and directed scenarios.
module tb_axis_pkt_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int UW = 4;
   localparam int KW = DW / 8;
   localparam int GW = 2;

   typedef struct {
      logic [DW-1:0] data;
      logic [UW-1:0] user;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic          aclk = 1'b0;
   logic          areset;
   logic [N-1:0]  input_enable;
   logic          grant_valid;
   logic [GW-1:0] grant_idx;

   axis_pkt_rr_arbiter_if #(.NUM_INPUTS(N), .AXIS_BUS_WIDTH(DW), .AXIS_USER_WIDTH(UW)) bus ();

   axis_pkt_rr_arbiter #(.NUM_INPUTS(N), .AXIS_BUS_WIDTH(DW), .AXIS_USER_WIDTH(UW)) dut (
      .aclk         (aclk),
      .areset       (areset),
      .bus          (bus),
      .input_enable (input_enable),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx)
   );

   always #5 aclk = ~aclk;

   // sources and environment controls
   beat_t        srcq[N][$];
   logic [N-1:0] hold = '0;
   int           rmode = 0;
   int           pkt_seq = 0;
   int           acc_cnt[N];

   // reference: current owner (-1 none), last owner, shown grant index, output slot
   bit           known = 0;
   int           owner = -1;
   int           last_g = N - 1;
   int           gshow = 0;
   beat_t        outq[$];

   // observation logs
   int           dut_grants[$];
   beat_t        outlog[$];
   logic [N-1:0] seen_ready = '0;

   int           total = 0;
   int           bad = 0;

   logic [N-1:0] hs, req, exp_rdy;
   bit           prev_gv = 0;
   beat_t        ob;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (srcq[i].size() > 0) begin
            bus.s_axis_tdata[i*DW +: DW] = srcq[i][0].data;
            bus.s_axis_tuser[i*UW +: UW] = srcq[i][0].user;
            bus.s_axis_tkeep[i*KW +: KW] = srcq[i][0].keep;
            bus.s_axis_tlast[i]          = srcq[i][0].last;
            bus.s_axis_tvalid[i]         = !hold[i];
         end else begin
            bus.s_axis_tlast[i]  = 1'b0;
            bus.s_axis_tvalid[i] = 1'b0;
         end
      end
   endtask

   task automatic push_pkt(input int src, input int len);
      beat_t b;
      for (int j = 0; j < len; j++) begin
         b.data = {8'(src), 24'(pkt_seq), 32'(j)};
         b.user = 4'($urandom);
         b.keep = 8'($urandom) | 8'h01;
         b.last = (j == len - 1);
         srcq[src].push_back(b);
      end
      pkt_seq++;
   endtask

   task automatic wait_idle(input logic [N-1:0] mask, input string name);
      int cyc;
      bit done;
      cyc  = 0;
      done = 0;
      while (!done && cyc < 6000) begin
         @(posedge aclk); #2;
         cyc++;
         done = (grant_valid === 1'b0) && (bus.m_axis_tvalid === 1'b0) && (outq.size() == 0);
         for (int i = 0; i < N; i++) begin
            if (mask[i] && srcq[i].size() > 0) done = 0;
         end
      end
      chk(name, 64'(done), 64'd1);
   endtask

   task automatic do_reset();
      @(posedge aclk); #2;
      areset = 1'b1;
      hold   = '0;
      for (int i = 0; i < N; i++) srcq[i].delete();
      @(posedge aclk); #2;
      areset = 1'b0;
   endtask

   task automatic wait_accept(input int src, input string name);
      int base, cyc;
      base = acc_cnt[src];
      cyc  = 0;
      while (acc_cnt[src] == base && cyc < 200) begin
         @(posedge aclk); #2;
         cyc++;
      end
      chk(name, 64'(acc_cnt[src] != base), 64'd1);
   endtask

   // Per-cycle reference check at the falling edge, then advance the reference
   // to what the next rising edge must do; sources update just after that edge.
   initial begin : engine
      forever begin
         @(negedge aclk);
         exp_rdy = '0;
         if (owner >= 0 && (outq.size() == 0 || bus.m_axis_tready)) exp_rdy[owner] = 1'b1;
         if (known) begin
            chk("grant_valid", 64'(grant_valid), 64'(owner >= 0));
            chk("grant_idx", 64'(grant_idx), 64'(gshow));
            chk("s_tready", 64'(bus.s_axis_tready), 64'(exp_rdy));
            chk("m_tvalid", 64'(bus.m_axis_tvalid), 64'(outq.size() > 0));
            if (outq.size() > 0 && bus.m_axis_tvalid === 1'b1) begin
               chk("m_tdata", bus.m_axis_tdata, outq[0].data);
               chk("m_tuser", 64'(bus.m_axis_tuser), 64'(outq[0].user));
               chk("m_tkeep", 64'(bus.m_axis_tkeep), 64'(outq[0].keep));
               chk("m_tlast", 64'(bus.m_axis_tlast), 64'(outq[0].last));
            end
         end
         if (!areset) seen_ready |= bus.s_axis_tready;
         if (grant_valid === 1'b1 && !prev_gv) dut_grants.push_back(int'(grant_idx));
         prev_gv = (grant_valid === 1'b1);
         if (!areset && bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready) begin
            ob.data = bus.m_axis_tdata;
            ob.user = bus.m_axis_tuser;
            ob.keep = bus.m_axis_tkeep;
            ob.last = bus.m_axis_tlast;
            outlog.push_back(ob);
         end
         hs = areset ? '0 : (bus.s_axis_tvalid & bus.s_axis_tready);

         if (areset) begin
            owner  = -1;
            last_g = N - 1;
            gshow  = 0;
            outq.delete();
            known  = 1;
         end else if (known) begin
            if (outq.size() > 0 && bus.m_axis_tready) void'(outq.pop_front());
            if (owner < 0) begin
               req = bus.s_axis_tvalid & input_enable;
               if (req != '0) begin
                  owner = rr_pick(last_g, req);
                  gshow = owner;
               end
            end else if (exp_rdy[owner] && bus.s_axis_tvalid[owner] && srcq[owner].size() > 0) begin
               outq.push_back(srcq[owner][0]);
               if (srcq[owner][0].last) begin
                  last_g = owner;
                  owner  = -1;
               end
            end
         end

         @(posedge aclk); #1;
         for (int i = 0; i < N; i++) begin
            if (hs[i] && srcq[i].size() > 0) begin
               void'(srcq[i].pop_front());
               acc_cnt[i]++;
            end
         end
         bus.m_axis_tready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         drive();
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int exp2[8];
      int exp3[4];
      int nbeats;
      exp2 = '{0, 1, 2, 3, 0, 1, 2, 3};
      exp3 = '{1, 3, 1, 3};
      for (int i = 0; i < N; i++) acc_cnt[i] = 0;
      areset            = 1'b1;
      input_enable      = '1;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tuser  = '0;
      bus.s_axis_tkeep  = '0;
      bus.s_axis_tlast  = '0;
      bus.s_axis_tvalid = '0;
      bus.m_axis_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #2;
      chk("rst_grant_valid", 64'(grant_valid), 64'd0);
      chk("rst_grant_idx", 64'(grant_idx), 64'd0);
      chk("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      chk("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
      areset = 1'b0;

      // single 3-beat packet from input 2
      dut_grants.delete();
      outlog.delete();
      push_pkt(2, 3);
      wait_idle(4'hF, "t1_idle");
      chk("t1_ngrants", 64'(dut_grants.size()), 64'd1);
      if (dut_grants.size() > 0) chk("t1_grant", 64'(dut_grants[0]), 64'd2);
      chk("t1_nbeats", 64'(outlog.size()), 64'd3);
      for (int j = 0; j < outlog.size() && j < 3; j++) begin
         chk("t1_data", outlog[j].data, 64'h0200_0000_0000_0000 + 64'(j));
         chk("t1_last", 64'(outlog[j].last), 64'(j == 2));
      end

      // rotation over all inputs, 2-beat packets
      do_reset();
      dut_grants.delete();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) push_pkt(i, 2);
      end
      wait_idle(4'hF, "t2_idle");
      chk("t2_ngrants", 64'(dut_grants.size()), 64'd8);
      for (int k = 0; k < 8 && k < dut_grants.size(); k++) chk("t2_order", 64'(dut_grants[k]), 64'(exp2[k]));

      // masking: only inputs 1 and 3 enabled
      do_reset();
      dut_grants.delete();
      input_enable = 4'b1010;
      seen_ready   = '0;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) push_pkt(i, 2);
      end
      wait_idle(4'b1010, "t3_idle");
      chk("t3_ngrants", 64'(dut_grants.size()), 64'd4);
      for (int k = 0; k < 4 && k < dut_grants.size(); k++) chk("t3_order", 64'(dut_grants[k]), 64'(exp3[k]));
      chk("t3_masked_ready", 64'(seen_ready & 4'b0101), 64'd0);
      srcq[0].delete();
      srcq[2].delete();
      repeat (3) @(posedge aclk);
      #2;
      input_enable = 4'hF;

      // random backpressure, 100 packets of 1..16 beats
      outlog.delete();
      nbeats = 0;
      rmode  = 1;
      for (int p = 0; p < 100; p++) begin
         int src, len;
         src = $urandom_range(0, N - 1);
         len = $urandom_range(1, 16);
         push_pkt(src, len);
         nbeats += len;
      end
      wait_idle(4'hF, "t4_idle");
      rmode = 0;
      chk("t4_nbeats", 64'(outlog.size()), 64'(nbeats));

      // mid-packet enable clear and tvalid drop on input 1
      do_reset();
      dut_grants.delete();
      push_pkt(1, 4);
      wait_accept(1, "t5_first_beat");
      hold[1]         = 1'b1;
      input_enable[1] = 1'b0;
      push_pkt(0, 2);
      push_pkt(3, 2);
      for (int c = 0; c < 5; c++) begin
         @(posedge aclk); #2;
         chk("t5_hold_gv", 64'(grant_valid), 64'd1);
         chk("t5_hold_idx", 64'(grant_idx), 64'd1);
      end
      hold[1] = 1'b0;
      wait_idle(4'hF, "t5_idle");
      chk("t5_ngrants", 64'(dut_grants.size()), 64'd3);
      if (dut_grants.size() > 2) begin
         chk("t5_g0", 64'(dut_grants[0]), 64'd1);
         chk("t5_g1", 64'(dut_grants[1]), 64'd3);
         chk("t5_g2", 64'(dut_grants[2]), 64'd0);
      end
      input_enable = 4'hF;

      // reset during beat 2 of a 5-beat packet
      do_reset();
      push_pkt(2, 5);
      wait_accept(2, "t6_first_beat");
      areset = 1'b1;
      srcq[2].delete();
      @(posedge aclk); #2;
      chk("t6_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      chk("t6_s_tready", 64'(bus.s_axis_tready), 64'd0);
      chk("t6_grant_valid", 64'(grant_valid), 64'd0);
      chk("t6_grant_idx", 64'(grant_idx), 64'd0);
      areset = 1'b0;
      dut_grants.delete();
      push_pkt(3, 2);
      push_pkt(1, 2);
      wait_idle(4'hF, "t6_idle");
      chk("t6_ngrants", 64'(dut_grants.size()), 64'd2);
      if (dut_grants.size() > 1) begin
         chk("t6_g0", 64'(dut_grants[0]), 64'd1);
         chk("t6_g1", 64'(dut_grants[1]), 64'd3);
      end

      repeat (2) @(posedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
